// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared widths and load-source priority indices for the control datapath
package ctrl_pkg;
  localparam int DEF_WIDTH = 12;
  localparam int SRC_ARR   = 0;
  localparam int SRC_START = 1;
  localparam int SRC_ADDR1 = 2;
  localparam int SRC_ADDR2 = 3;
endpackage

// File: rtl/select_stack.sv
// select_stack: DEPTH x WIDTH return stack with push, pop, exchange and error pulses
module select_stack
  import ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = 4,
  localparam int DW = $clog2(DEPTH + 1),
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic [DW-1:0]    depth,
  output logic             full,
  output logic             empty,
  output logic             ovf,
  output logic             unf
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [DW-1:0] dm1;
  logic pop_ok, exch, wr, inc, dec;
  logic [AW-1:0] waddr;
  assign full   = depth == DW'(DEPTH);
  assign empty  = depth == '0;
  assign dm1    = depth - DW'(1);
  assign top    = mem[dm1[AW-1:0]];
  assign pop_ok = pop & ~empty;
  assign exch   = push & pop_ok;
  assign wr     = push & (exch | ~full);
  assign waddr  = exch ? dm1[AW-1:0] : depth[AW-1:0];
  assign inc    = push & ~pop_ok & ~full;
  assign dec    = pop_ok & ~push;
  assign ovf    = push & full & ~pop_ok;
  assign unf    = pop & empty;
  // Entry storage: an exchange overwrites the top, a plain push fills the next free slot
  always_ff @(posedge clk) begin
    if (wr) mem[waddr] <= din;
  end
  // Occupancy counter; an exchange leaves it unchanged
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) depth <= '0;
    else depth <= inc ? depth + DW'(1) : dec ? dm1 : depth;
  end
endmodule

// File: rtl/select_reg_stack.sv
// select_reg_stack: prioritised-load select register with signed stepping and a return stack
module select_reg_stack
  import ctrl_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int NUM_SRC = 4,
  parameter int DEPTH   = 4
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [NUM_SRC-1:0]         load_en,
  input  logic [NUM_SRC*WIDTH-1:0]   load_data,
  input  logic                       step_en,
  input  logic [WIDTH-1:0]           step_value,
  input  logic                       push_en,
  input  logic                       pop_en,
  input  logic                       err_clr,
  output logic [WIDTH-1:0]           reg_select_value,
  output logic [$clog2(DEPTH+1)-1:0] stack_depth,
  output logic                       stack_full,
  output logic                       stack_empty,
  output logic                       wrap,
  output logic                       err_ovf,
  output logic                       err_unf
);
  logic ld_any, pop_eff, pop_take, carry, ovf, unf;
  logic [WIDTH-1:0] ld_val, sum, top, nxt;
  // Lowest set load index wins, so scan from the top index downwards
  always_comb begin
    ld_val = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) ld_val = load_en[i] ? load_data[i*WIDTH +: WIDTH] : ld_val;
  end
  assign ld_any   = |load_en;
  assign pop_eff  = pop_en & ~ld_any;
  assign pop_take = pop_eff & ~stack_empty;
  assign {carry, sum} = {1'b0, reg_select_value} + {1'b0, step_value};
  assign nxt = ld_any ? ld_val : pop_take ? top : step_en ? sum : reg_select_value;
  select_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_stack (
    .clk(clk),
    .resetn(resetn),
    .push(push_en),
    .pop(pop_eff),
    .din(reg_select_value),
    .top(top),
    .depth(stack_depth),
    .full(stack_full),
    .empty(stack_empty),
    .ovf(ovf),
    .unf(unf)
  );
  // Register, boundary-crossing pulse and sticky errors; a new error outranks err_clr
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      reg_select_value <= '0;
      wrap             <= 1'b0;
      err_ovf          <= 1'b0;
      err_unf          <= 1'b0;
    end else begin
      reg_select_value <= nxt;
      wrap             <= ~ld_any & ~pop_take & step_en & (carry ^ step_value[WIDTH-1]);
      err_ovf          <= (err_ovf & ~err_clr) | ovf;
      err_unf          <= (err_unf & ~err_clr) | unf;
    end
  end
endmodule

// File: tb/tb_select_reg_stack.sv
// tb_select_reg_stack: directed plus random checks against a queue-based reference model
module tb_select_reg_stack;
  localparam int W = 12, N = 4, D = 4;
  logic clk = 0, resetn = 0;
  logic [N-1:0] load_en = '0;
  logic [N*W-1:0] load_data = '0;
  logic step_en = 0, push_en = 0, pop_en = 0, err_clr = 0;
  logic [W-1:0] step_value = '0;
  logic [W-1:0] reg_select_value;
  logic [$clog2(D+1)-1:0] stack_depth;
  logic stack_full, stack_empty, wrap, err_ovf, err_unf;
  int n_checks = 0, n_fail = 0;
  int m_reg, m_wrap, m_ovf, m_unf;
  int q[$];

  select_reg_stack #(.WIDTH(W), .NUM_SRC(N), .DEPTH(D)) dut (
    .clk(clk), .resetn(resetn), .load_en(load_en), .load_data(load_data),
    .step_en(step_en), .step_value(step_value), .push_en(push_en), .pop_en(pop_en),
    .err_clr(err_clr), .reg_select_value(reg_select_value), .stack_depth(stack_depth),
    .stack_full(stack_full), .stack_empty(stack_empty), .wrap(wrap),
    .err_ovf(err_ovf), .err_unf(err_unf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    check("reg", 32'(reg_select_value), 32'(m_reg));
    check("depth", 32'(stack_depth), 32'(q.size()));
    check("full", 32'(stack_full), 32'(q.size() == D));
    check("empty", 32'(stack_empty), 32'(q.size() == 0));
    check("wrap", 32'(wrap), 32'(m_wrap));
    check("err_ovf", 32'(err_ovf), 32'(m_ovf));
    check("err_unf", 32'(err_unf), 32'(m_unf));
  endtask

  task automatic model_reset();
    m_reg = 0; m_wrap = 0; m_ovf = 0; m_unf = 0;
    q.delete();
  endtask

  // Reference behaviour at one rising edge, computed from the current inputs
  task automatic model_step();
    int src, nr, sv, top_val;
    bit popped, new_ovf, new_unf;
    src = -1;
    for (int i = N - 1; i >= 0; i--) if (load_en[i]) src = i;
    popped = 0; new_ovf = 0; new_unf = 0; top_val = 0;
    m_wrap = 0;
    if (src < 0 && pop_en && push_en && q.size() > 0) begin
      top_val = q[q.size()-1];
      q[q.size()-1] = m_reg;
      popped = 1;
    end else begin
      if (src < 0 && pop_en) begin
        if (q.size() == 0) new_unf = 1;
        else begin top_val = q.pop_back(); popped = 1; end
      end
      if (push_en) begin
        if (q.size() == D) new_ovf = 1;
        else q.push_back(m_reg);
      end
    end
    if (src >= 0) m_reg = int'(load_data[src*W +: W]);
    else if (popped) m_reg = top_val;
    else if (step_en) begin
      sv = step_value[W-1] ? int'(step_value) - (1 << W) : int'(step_value);
      nr = m_reg + sv;
      m_wrap = (nr < 0 || nr >= (1 << W)) ? 1 : 0;
      m_reg = nr & ((1 << W) - 1);
    end
    if (err_clr) begin m_ovf = 0; m_unf = 0; end
    if (new_ovf) m_ovf = 1;
    if (new_unf) m_unf = 1;
  endtask

  task automatic cyc(input logic [N-1:0] le, input logic [N*W-1:0] ld, input logic st,
                     input logic [W-1:0] sv, input logic pu, input logic po, input logic cl);
    @(negedge clk);
    load_en = le; load_data = ld; step_en = st; step_value = sv;
    push_en = pu; pop_en = po; err_clr = cl;
    @(posedge clk);
    model_step();
    #1 check_all();
  endtask

  function automatic logic [N*W-1:0] src_at(input int i, input logic [W-1:0] v);
    logic [N*W-1:0] r;
    r = '0;
    r[i*W +: W] = v;
    return r;
  endfunction

  task automatic async_reset();
    @(posedge clk);
    #3 resetn = 0;
    model_reset();
    #1 check_all();
    @(negedge clk);
    load_en = '0; step_en = 0; push_en = 0; pop_en = 0; err_clr = 0;
    resetn = 1;
  endtask

  initial begin
    model_reset();
    #12 resetn = 1;
    cyc(4'b0001, src_at(0, 12'h5A5), 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    async_reset();
    // load priority
    cyc(4'b1100, src_at(2, 12'h123) | src_at(3, 12'h456), 0, 0, 0, 0, 0);
    check("ld_pri_a", 32'(reg_select_value), 32'h123);
    cyc(4'b1001, src_at(0, 12'h7AA) | src_at(3, 12'h456), 1, 12'h001, 0, 1, 0);
    check("ld_pri_b", 32'(reg_select_value), 32'h7AA);
    // step and wrap
    cyc(4'b0001, src_at(0, 12'hFFE), 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 12'h001, 0, 0, 0);
    check("step_fff", 32'(reg_select_value), 32'hFFF);
    cyc(0, 0, 1, 12'h001, 0, 0, 0);
    check("wrap_up", 32'({wrap, reg_select_value}), 32'h1000);
    cyc(0, 0, 1, 12'hFFF, 0, 0, 0);
    check("wrap_dn", 32'({wrap, reg_select_value}), 32'h1FFF);
    cyc(0, 0, 0, 0, 0, 0, 0);
    check("wrap_drop", 32'(wrap), 0);
    // stack round trip
    cyc(4'b0001, src_at(0, 12'h010), 0, 0, 0, 0, 0);
    cyc(4'b0001, src_at(0, 12'h020), 0, 0, 1, 0, 0);
    cyc(4'b0001, src_at(0, 12'h030), 0, 0, 1, 0, 0);
    cyc(4'b0001, src_at(0, 12'h040), 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    check("full4", 32'({stack_full, stack_depth}), 32'h C);
    cyc(0, 0, 0, 0, 1, 0, 0);
    check("ovf", 32'({err_ovf, stack_depth}), 32'hC);
    cyc(0, 0, 0, 0, 0, 1, 0);
    check("pop1", 32'(reg_select_value), 32'h040);
    cyc(0, 0, 0, 0, 0, 1, 0);
    check("pop2", 32'(reg_select_value), 32'h030);
    cyc(0, 0, 0, 0, 0, 1, 0);
    check("pop3", 32'(reg_select_value), 32'h020);
    cyc(0, 0, 0, 0, 0, 1, 0);
    check("pop4", 32'(reg_select_value), 32'h010);
    cyc(0, 0, 0, 0, 0, 1, 0);
    check("unf", 32'({err_unf, reg_select_value}), 32'h1010);
    cyc(0, 0, 0, 0, 0, 0, 1);
    check("clr", 32'({err_ovf, err_unf}), 0);
    // exchange
    cyc(4'b0001, src_at(0, 12'h222), 0, 0, 0, 0, 0);
    cyc(4'b0001, src_at(0, 12'h111), 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 1, 0);
    check("xchg", 32'({stack_depth, reg_select_value}), 32'h1222);
    cyc(0, 0, 0, 0, 0, 1, 0);
    check("xchg_top", 32'(reg_select_value), 32'h111);
    cyc(0, 0, 1, 12'h002, 1, 1, 0);
    check("xchg_empty", 32'({err_unf, stack_depth}), 32'h9);
    // load with push and pop: pop is dropped
    cyc(4'b0001, src_at(0, 12'h055), 0, 0, 0, 0, 1);
    cyc(4'b0010, src_at(1, 12'h300), 1, 12'h001, 1, 1, 0);
    check("ld_push", 32'({stack_depth, reg_select_value}), 32'h2300);
    cyc(0, 0, 0, 0, 0, 1, 0);
    check("ld_push_top", 32'(reg_select_value), 32'h055);
    // randomized traffic with one mid-run reset
    for (int k = 0; k < 600; k++) begin
      logic [N-1:0] le;
      logic [N*W-1:0] ld;
      if (k == 300) async_reset();
      le = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      ld = {$urandom, $urandom};
      cyc(le, ld, $urandom_range(0, 1) == 1,
          ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 1) ? 1 : 12'hFFF) : W'($urandom),
          $urandom_range(0, 9) < 4, $urandom_range(0, 9) < 4, $urandom_range(0, 9) == 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
